// File: rtl/spi_pkg.sv
// Shared types and constant helpers for the multi-chip-select SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_WAIT_WORD,
    ST_CS_HOLD,
    ST_CS_GAP
  } state_e;

  function automatic bit cpol_of(input int mode);
    return bit'((mode >> 1) & 1);
  endfunction

  function automatic bit cpha_of(input int mode);
    return bit'(mode & 1);
  endfunction

  function automatic int cnt_width(input int max_words);
    return $clog2(max_words + 1);
  endfunction

  function automatic int sel_width(input int num_cs);
    return (num_cs > 1) ? $clog2(num_cs) : 1;
  endfunction

endpackage

// File: rtl/spi_word_shifter.sv
// Bit-level SPI engine: half-bit timing, SCLK edges and TX/RX shift registers for one word.
module spi_word_shifter #(
  parameter bit CPOL              = 1'b0,
  parameter bit CPHA              = 1'b0,
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int WORD_WIDTH        = 8,
  parameter bit LSB_FIRST         = 1'b0
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  load_i,
  input  logic [WORD_WIDTH-1:0] tx_word_i,
  input  logic                  start_i,
  input  logic                  miso_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [WORD_WIDTH-1:0] rx_word_o,
  output logic                  sclk_o,
  output logic                  mosi_o
);

  localparam int HW = $clog2(CLKS_PER_HALF_BIT);
  localparam int EW = $clog2(2 * WORD_WIDTH);

  logic                  busy_q;
  logic [HW-1:0]         hcnt_q;
  logic [EW-1:0]         ecnt_q;
  logic [WORD_WIDTH-1:0] tx_q;
  logic [WORD_WIDTH-1:0] rx_q;
  logic                  sclk_q;
  logic                  mosi_q;

  logic                  edge_now;
  logic                  leading;
  logic                  sample_now;
  logic                  update_now;
  logic                  last_edge;
  logic [WORD_WIDTH-1:0] rx_shift;

  assign edge_now   = busy_q && (hcnt_q == HW'(CLKS_PER_HALF_BIT - 1));
  assign leading    = ~ecnt_q[0];
  assign last_edge  = edge_now && (ecnt_q == EW'(2 * WORD_WIDTH - 1));
  assign sample_now = edge_now && (leading ^ CPHA);
  // First bit is already on MOSI from load, so the edge that would present bit 0 is skipped.
  assign update_now = edge_now && (CPHA ? (leading && (ecnt_q != '0))
                                        : (!leading && !last_edge));
  assign rx_shift   = LSB_FIRST ? {miso_i, rx_q[WORD_WIDTH-1:1]}
                                : {rx_q[WORD_WIDTH-2:0], miso_i};

  always_ff @(posedge clk) begin
    if (srst) begin
      busy_q <= 1'b0;
      hcnt_q <= '0;
      ecnt_q <= '0;
      tx_q   <= '0;
      rx_q   <= '0;
      sclk_q <= CPOL;
      mosi_q <= 1'b0;
    end else begin
      if (load_i) begin
        tx_q   <= tx_word_i;
        mosi_q <= LSB_FIRST ? tx_word_i[0] : tx_word_i[WORD_WIDTH-1];
      end
      if (start_i) begin
        busy_q <= 1'b1;
        hcnt_q <= '0;
        ecnt_q <= '0;
        rx_q   <= '0;
      end else if (busy_q) begin
        if (edge_now) begin
          hcnt_q <= '0;
          sclk_q <= ~sclk_q;
          ecnt_q <= ecnt_q + EW'(1);
          if (sample_now) rx_q <= rx_shift;
          if (update_now) begin
            tx_q   <= LSB_FIRST ? (tx_q >> 1) : (tx_q << 1);
            mosi_q <= LSB_FIRST ? tx_q[1] : tx_q[WORD_WIDTH-2];
          end
          if (last_edge) busy_q <= 1'b0;
        end else begin
          hcnt_q <= hcnt_q + HW'(1);
        end
      end
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = last_edge;
  assign rx_word_o = sample_now ? rx_shift : rx_q;
  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;

endmodule

// File: rtl/spi_master_multi_cs.sv
// SPI master with multi-word bursts, selectable chip select and CS setup/hold/gap timing.
module spi_master_multi_cs
  import spi_pkg::*;
#(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int WORD_WIDTH        = 8,
  parameter int LSB_FIRST         = 0,
  parameter int NUM_CS            = 2,
  parameter int MAX_WORDS         = 4,
  parameter int CS_INACTIVE_CLKS  = 2,
  localparam int CW               = cnt_width(MAX_WORDS),
  localparam int SW               = sel_width(NUM_CS)
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic [CW-1:0]         i_TX_Count,
  input  logic [SW-1:0]         i_CS_Sel,
  input  logic [WORD_WIDTH-1:0] i_TX_Word,
  input  logic                  i_TX_DV,
  output logic                  o_TX_Ready,
  output logic                  o_RX_DV,
  output logic [WORD_WIDTH-1:0] o_RX_Word,
  output logic [CW-1:0]         o_RX_Count,
  output logic                  o_SPI_Clk,
  input  logic                  i_SPI_MISO,
  output logic                  o_SPI_MOSI,
  output logic [NUM_CS-1:0]     o_SPI_CS_n
);

  localparam int MAXT = (CLKS_PER_HALF_BIT > CS_INACTIVE_CLKS) ? CLKS_PER_HALF_BIT
                                                               : CS_INACTIVE_CLKS;
  localparam int TW   = $clog2(MAXT + 1);

  state_e                state_q;
  logic                  ready_q;
  logic                  rx_dv_q;
  logic [WORD_WIDTH-1:0] rx_word_q;
  logic [CW-1:0]         rx_count_q;
  logic [NUM_CS-1:0]     cs_n_q;
  logic [CW-1:0]         total_q;
  logic [CW-1:0]         idx_q;
  logic [TW-1:0]         cnt_q;

  logic                  accept;
  logic                  sh_start;
  logic                  sh_busy;
  logic                  sh_done;
  logic [WORD_WIDTH-1:0] sh_rx_word;
  logic [NUM_CS-1:0]     cs_dec_n;

  // An out-of-range select leaves every line high while the burst still runs.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
      assign cs_dec_n[gi] = (i_CS_Sel != SW'(gi));
    end
  endgenerate

  assign accept   = i_TX_DV && ready_q;
  assign sh_start = (state_q == ST_CS_SETUP) && (cnt_q == TW'(CLKS_PER_HALF_BIT - 1)) && !sh_busy;

  spi_word_shifter #(
    .CPOL             (cpol_of(SPI_MODE)),
    .CPHA             (cpha_of(SPI_MODE)),
    .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT),
    .WORD_WIDTH       (WORD_WIDTH),
    .LSB_FIRST        (LSB_FIRST != 0)
  ) u_shifter (
    .clk      (i_Clk),
    .srst     (i_Rst),
    .load_i   (accept),
    .tx_word_i(i_TX_Word),
    .start_i  (sh_start),
    .miso_i   (i_SPI_MISO),
    .busy_o   (sh_busy),
    .done_o   (sh_done),
    .rx_word_o(sh_rx_word),
    .sclk_o   (o_SPI_Clk),
    .mosi_o   (o_SPI_MOSI)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b1;
      rx_dv_q    <= 1'b0;
      rx_word_q  <= '0;
      rx_count_q <= '0;
      cs_n_q     <= '1;
      total_q    <= CW'(1);
      idx_q      <= '0;
      cnt_q      <= '0;
    end else begin
      rx_dv_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            total_q <= (i_TX_Count == '0) ? CW'(1) : i_TX_Count;
            idx_q   <= '0;
            cs_n_q  <= cs_dec_n;
            ready_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_CS_SETUP;
          end
        end
        ST_CS_SETUP: begin
          if (cnt_q == TW'(CLKS_PER_HALF_BIT - 1)) begin
            cnt_q   <= '0;
            state_q <= ST_SHIFT;
          end else begin
            cnt_q <= cnt_q + TW'(1);
          end
        end
        ST_SHIFT: begin
          if (sh_done) begin
            rx_dv_q    <= 1'b1;
            rx_word_q  <= sh_rx_word;
            rx_count_q <= idx_q;
            idx_q      <= idx_q + CW'(1);
            if ((idx_q + CW'(1)) < total_q) begin
              ready_q <= 1'b1;
              state_q <= ST_WAIT_WORD;
            end else begin
              cnt_q   <= '0;
              state_q <= ST_CS_HOLD;
            end
          end
        end
        ST_WAIT_WORD: begin
          if (accept) begin
            ready_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_CS_SETUP;
          end
        end
        ST_CS_HOLD: begin
          if (cnt_q == TW'(CLKS_PER_HALF_BIT - 1)) begin
            cs_n_q  <= '1;
            cnt_q   <= '0;
            state_q <= ST_CS_GAP;
          end else begin
            cnt_q <= cnt_q + TW'(1);
          end
        end
        ST_CS_GAP: begin
          if (cnt_q == TW'(CS_INACTIVE_CLKS - 1)) begin
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + TW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_TX_Ready = ready_q;
  assign o_RX_DV    = rx_dv_q;
  assign o_RX_Word  = rx_word_q;
  assign o_RX_Count = rx_count_q;
  assign o_SPI_CS_n = cs_n_q;

endmodule
